// File: rtl/doodle_physics_if.sv
// Handshake/bus bundle between the game controller side (keyboard decoder,
// platform collision, renderer) and doodle_physics.
//   master : drives frame_tick/start/keycode/land, observes sprite state
//   slave  : doodle_physics itself
interface doodle_physics_if #(
    parameter int POS_W = 10,
    parameter int VEL_W = 6
);
    logic                    frame_tick;
    logic                    start;
    logic [7:0]              keycode;
    logic                    land;
    logic [POS_W-1:0]        Doodle_X_out;
    logic [POS_W-1:0]        Doodle_Y_out;
    logic signed [VEL_W-1:0] y_speed_out;
    logic [1:0]              state_out;
    logic [POS_W-1:0]        scroll_amt;
    logic                    scroll_valid;
    logic                    dead;

    modport master (
        output frame_tick, start, keycode, land,
        input  Doodle_X_out, Doodle_Y_out, y_speed_out, state_out,
               scroll_amt, scroll_valid, dead
    );

    modport slave (
        input  frame_tick, start, keycode, land,
        output Doodle_X_out, Doodle_Y_out, y_speed_out, state_out,
               scroll_amt, scroll_valid, dead
    );
endinterface

// File: rtl/doodle_physics.sv
// Player sprite motion: position, signed vertical velocity, jump cooldown,
// IDLE/AIR/DEAD game state, platform bounce, camera scroll and
// terminal-velocity clamp. Updates once per frame_tick while in AIR.
// Ports:
//   Clk     - system clock
//   Reset_n - asynchronous active-low reset
//   bus     - doodle_physics_if.slave (pulses/keys in, sprite state out)
module doodle_physics #(
    parameter int W           = 640,
    parameter int H           = 480,
    parameter int X_MIN       = 140,
    parameter int X_MAX       = 499,
    parameter int SIZE_X      = 32,
    parameter int SIZE_Y      = 32,
    parameter int POS_W       = 10,
    parameter int VEL_W       = 6,
    parameter int X_STEP      = 1,
    parameter int GRAVITY     = 1,
    parameter int V_TERM      = 3,
    parameter int V_JUMP      = 9,
    parameter int V_BOUNCE    = 7,
    parameter int JUMP_CD     = 18,
    parameter int Y_TOP       = 11,
    parameter int SCROLL_LINE = 160
) (
    input  logic             Clk,
    input  logic             Reset_n,
    doodle_physics_if.slave  bus
);
    // Working width for position arithmetic: two spare bits so that
    // out-of-range intermediate positions are representable as signed.
    localparam int YW   = POS_W + 2;
    localparam int CD_W = $clog2(JUMP_CD + 1);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_AIR  = 2'b01;
    localparam logic [1:0] S_DEAD = 2'b10;

    localparam logic [POS_W-1:0] X_C = POS_W'((W - SIZE_X) / 2);
    localparam logic [POS_W-1:0] Y_C = POS_W'(H * 2 / 3);

    localparam logic signed [YW-1:0] X_STEP_S = YW'(X_STEP);
    localparam logic signed [YW-1:0] X_LO_S   = YW'(X_MIN);
    localparam logic signed [YW-1:0] X_HI_S   = YW'(X_MAX - SIZE_X);
    localparam logic signed [YW-1:0] Y_BOT_S  = YW'(H - 2 - SIZE_Y);
    localparam logic signed [YW-1:0] SCROLL_S = YW'(SCROLL_LINE);
    localparam logic signed [YW-1:0] Y_TOP_S  = YW'(Y_TOP);
    localparam logic signed [YW-1:0] GRAV_S   = YW'(GRAVITY);
    localparam logic signed [YW-1:0] V_TERM_S = YW'(V_TERM);

    localparam logic signed [VEL_W-1:0] V_JUMP_N   = VEL_W'(-V_JUMP);
    localparam logic signed [VEL_W-1:0] V_BOUNCE_N = VEL_W'(-V_BOUNCE);

    logic [POS_W-1:0]        x_q, x_d, y_q, y_d, samt_q, samt_d;
    logic signed [VEL_W-1:0] v_q, v_d;
    logic [CD_W-1:0]         cd_q, cd_d;
    logic [1:0]              st_q, st_d;
    logic                    sv_q, sv_d;

    logic signed [YW-1:0] x_new, y_ext, v_ext, y_new, v_grav, y_cand, y_gap;

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        v_d    = v_q;
        cd_d   = cd_q;
        st_d   = st_q;
        samt_d = samt_q;
        sv_d   = 1'b0;

        x_new = {2'b00, x_q};
        if (bus.keycode == 8'h04)      x_new = x_new - X_STEP_S;
        else if (bus.keycode == 8'h07) x_new = x_new + X_STEP_S;

        y_ext  = {2'b00, y_q};
        v_ext  = {{(YW-VEL_W){v_q[VEL_W-1]}}, v_q};
        y_new  = y_ext + v_ext;
        v_grav = v_ext + GRAV_S;
        if (v_grav > V_TERM_S) v_grav = V_TERM_S;

        // Scroll pins the sprite at the scroll line; the top clamp is a
        // safety net for parameter sets where the line sits above Y_TOP.
        y_cand = (y_new < SCROLL_S) ? SCROLL_S : y_new;
        if (y_cand < Y_TOP_S) y_cand = Y_TOP_S;
        y_gap  = SCROLL_S - y_new;

        // start wins over a coincident tick; in AIR start is a no-op.
        if (bus.start && st_q != S_AIR) begin
            x_d  = X_C;
            y_d  = Y_C;
            v_d  = V_JUMP_N;
            cd_d = '0;
            st_d = S_AIR;
        end else if (bus.frame_tick && st_q == S_AIR) begin
            if (x_new > X_HI_S)      x_d = X_LO_S[POS_W-1:0];
            else if (x_new < X_LO_S) x_d = X_HI_S[POS_W-1:0];
            else                     x_d = x_new[POS_W-1:0];

            if (cd_q != '0) cd_d = cd_q - 1'b1;
            if (bus.land && !v_q[VEL_W-1]) begin
                v_d = V_BOUNCE_N;
            end else if (bus.keycode == 8'h2C && cd_q == '0) begin
                v_d  = V_JUMP_N;
                cd_d = CD_W'(JUMP_CD);
            end else begin
                v_d = v_grav[VEL_W-1:0];
            end

            // Falling past the bottom freezes Y where it was.
            if (y_new > Y_BOT_S) begin
                st_d = S_DEAD;
            end else begin
                y_d = y_cand[POS_W-1:0];
                if (y_new < SCROLL_S) begin
                    samt_d = y_gap[POS_W-1:0];
                    sv_d   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            x_q    <= X_C;
            y_q    <= Y_C;
            v_q    <= '0;
            cd_q   <= '0;
            st_q   <= S_IDLE;
            samt_q <= '0;
            sv_q   <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            v_q    <= v_d;
            cd_q   <= cd_d;
            st_q   <= st_d;
            samt_q <= samt_d;
            sv_q   <= sv_d;
        end
    end

    assign bus.Doodle_X_out = x_q;
    assign bus.Doodle_Y_out = y_q;
    assign bus.y_speed_out  = v_q;
    assign bus.state_out    = st_q;
    assign bus.scroll_amt   = samt_q;
    assign bus.scroll_valid = sv_q;
    assign bus.dead         = (st_q == S_DEAD);
endmodule

// File: tb/tb_doodle_physics.sv
// Randomized scoreboard bench for doodle_physics. The driver applies
// pulses and pushes the expected sprite state computed by a plain
// arithmetic game model; a separate monitor pops and compares one Clk later.
module tb_doodle_physics;
    localparam int X_C    = (640 - 32) / 2;   // 304
    localparam int Y_C    = 480 * 2 / 3;      // 320
    localparam int Y_BOT  = 480 - 2 - 32;     // 446
    localparam int X_LO   = 140;
    localparam int X_HI   = 499 - 32;         // 467
    localparam int SCROLL = 160;
    localparam int ST_IDLE = 0, ST_AIR = 1, ST_DEAD = 2;

    typedef struct {
        int x, y, v, cd, st, samt;
        bit sv;
    } mdl_t;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    always #10 Clk = ~Clk;

    doodle_physics_if ifc ();
    doodle_physics dut (.Clk(Clk), .Reset_n(Reset_n), .bus(ifc));

    mdl_t m;
    mdl_t expq[$];
    int checks = 0;
    int failures = 0;

    task automatic cmp(string nm, int act, int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(string tag, mdl_t e);
        cmp({tag, ".x"},     int'(ifc.Doodle_X_out), e.x);
        cmp({tag, ".y"},     int'(ifc.Doodle_Y_out), e.y);
        cmp({tag, ".v"},     int'(ifc.y_speed_out),  e.v);
        cmp({tag, ".state"}, int'(ifc.state_out),    e.st);
        cmp({tag, ".samt"},  int'(ifc.scroll_amt),   e.samt);
        cmp({tag, ".sv"},    int'(ifc.scroll_valid), int'(e.sv));
        cmp({tag, ".dead"},  int'(ifc.dead),         (e.st == ST_DEAD) ? 1 : 0);
    endtask

    function automatic mdl_t mreset();
        mdl_t r;
        r.x = X_C; r.y = Y_C; r.v = 0; r.cd = 0; r.st = ST_IDLE; r.samt = 0; r.sv = 0;
        return r;
    endfunction

    // One game update as the rules read: start restarts from IDLE/DEAD,
    // a tick in AIR moves the sprite.
    function automatic mdl_t mstep(mdl_t s, bit st, bit tk, int kc, bit ld);
        mdl_t r = s;
        int xn, yn;
        r.sv = 0;
        if (st && s.st != ST_AIR) begin
            r.x = X_C; r.y = Y_C; r.v = -9; r.cd = 0; r.st = ST_AIR;
        end else if (tk && s.st == ST_AIR) begin
            xn = s.x + ((kc == 'h04) ? -1 : (kc == 'h07) ? 1 : 0);
            r.x = (xn > X_HI) ? X_LO : (xn < X_LO) ? X_HI : xn;
            yn = s.y + s.v;
            r.cd = (s.cd > 0) ? s.cd - 1 : 0;
            if (ld && s.v >= 0) r.v = -7;
            else if (kc == 'h2C && s.cd == 0) begin r.v = -9; r.cd = 18; end
            else r.v = (s.v + 1 > 3) ? 3 : s.v + 1;
            if (yn > Y_BOT) r.st = ST_DEAD;
            else if (yn < SCROLL) begin
                r.y = SCROLL; r.samt = SCROLL - yn; r.sv = 1;
            end else r.y = (yn < 11) ? 11 : yn;
        end
        return r;
    endfunction

    task automatic issue(bit s, bit t, int kc, bit ld);
        @(posedge Clk); #1;
        ifc.start = s; ifc.frame_tick = t; ifc.keycode = 8'(kc); ifc.land = ld;
        m = mstep(m, s, t, kc, ld);
        expq.push_back(m);
    endtask

    task automatic idle();
        @(posedge Clk); #1;
        ifc.start = 1'b0; ifc.frame_tick = 1'b0;
    endtask

    // Monitor: any pulse accepted at a posedge has its result checked at
    // the following negedge; otherwise scroll_valid must be low.
    initial begin
        bit p;
        mdl_t e;
        forever begin
            @(posedge Clk);
            p = Reset_n && (ifc.start || ifc.frame_tick);
            @(negedge Clk);
            if (p) begin
                if (expq.size() == 0) cmp("queue_underflow", 1, 0);
                else begin
                    e = expq.pop_front();
                    chk_all("step", e);
                end
            end else if (Reset_n) begin
                cmp("scroll_idle", int'(ifc.scroll_valid), 0);
            end
        end
    end

    initial begin
        repeat (60000) @(posedge Clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int kc, lmode, len;
        bit ld;
        ifc.start = 1'b0; ifc.frame_tick = 1'b0; ifc.keycode = 8'h00; ifc.land = 1'b0;
        m = mreset();
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk_all("reset", m);
        Reset_n = 1'b1;

        // First game: start, then a plain tick (Y 320->311, v -9->-8).
        issue(1, 0, 0, 0);
        issue(0, 1, 0, 0);
        idle(); idle();

        for (int ph = 0; ph < 25; ph++) begin
            case ($urandom_range(0, 4))
                0: kc = 'h04;
                1: kc = 'h07;
                2: kc = 'h2C;
                3: kc = 'h00;
                default: kc = $urandom_range(0, 255);
            endcase
            lmode = $urandom_range(0, 3);   // 0 never, 1/2 always, 3 coin flip
            len = $urandom_range(40, 220);
            for (int i = 0; i < len; i++) begin
                if (m.st != ST_AIR) begin
                    // Ticks in DEAD/IDLE are ignored; restart sometimes with
                    // a coincident tick, which start overrides.
                    repeat ($urandom_range(0, 2)) issue(0, 1, kc, 1'b1);
                    issue(1, $urandom_range(0, 1), kc, 1'b0);
                end else begin
                    ld = (lmode == 0) ? 1'b0 : (lmode == 3) ? 1'($urandom_range(0, 1)) : 1'b1;
                    if ($urandom_range(0, 30) == 0) issue(1, 0, kc, ld);   // ignored in AIR
                    issue(0, 1, kc, ld);
                end
                repeat ($urandom_range(0, 2)) idle();
            end
            idle();
        end

        // Asynchronous reset in the middle of a cycle while in AIR.
        if (m.st != ST_AIR) issue(1, 0, 0, 0);
        issue(0, 1, 'h07, 0);
        idle(); idle();
        @(posedge Clk); #3;
        Reset_n = 1'b0;
        #1;
        m = mreset();
        chk_all("async_reset", m);
        @(negedge Clk);
        Reset_n = 1'b1;

        // After release: tick in IDLE ignored, then a normal game start.
        issue(0, 1, 0, 0);
        issue(1, 0, 0, 0);
        issue(0, 1, 'h2C, 0);
        issue(0, 1, 'h2C, 0);
        idle(); idle(); idle();

        cmp("queue_drained", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/doodle_physics.md
# doodle_physics

Parametrised successor to the player-motion block. It holds the player sprite's position, signed vertical velocity and jump cooldown, and adds a start/play/dead state machine, platform-bounce input, camera-scroll output and terminal-velocity clamp. It sits between the keyboard decoder / platform-collision logic and the sprite renderer. It updates once per frame tick.

## Interface
- W, 640, screen width
- H, 480, screen height
- X_MIN, 140, leftmost playfield X
- X_MAX, 499, rightmost playfield X
- SIZE_X / SIZE_Y, 32 / 32, sprite size
- POS_W, 10, position width (unsigned)
- VEL_W, 6, velocity width (two's complement)
- X_STEP, 1, horizontal pixels per tick
- GRAVITY, 1, velocity increment per tick
- V_TERM, 3, maximum downward velocity
- V_JUMP, 9, jump velocity magnitude (applied as -V_JUMP)
- V_BOUNCE, 7, platform-bounce magnitude
- JUMP_CD, 18, jump cooldown in ticks
- Y_TOP, 11, hard top clamp
- SCROLL_LINE, 160, Y threshold that triggers camera scroll
- Clk  in  1  system clock (50 MHz)
- Reset_n  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-Clk pulse per frame (edge already detected)
- start  in  1  one-Clk pulse: begin or restart a game
- keycode  in  8  HID code: 0x04 left, 0x07 right, 0x2C jump
- land  in  1  sprite feet overlap a platform; sampled on frame_tick
- Doodle_X_out  out  POS_W  sprite X
- Doodle_Y_out  out  POS_W  sprite Y
- y_speed_out  out  VEL_W  signed vertical velocity
- state_out  out  2  00 IDLE, 01 AIR, 10 DEAD
- scroll_amt  out  POS_W  pixels to scroll the world down; valid with scroll_valid
- scroll_valid  out  1  one-Clk pulse
- dead  out  1  level, high in DEAD

## Operation
- X_C is (W-SIZE_X)/2. Y_C is H*2/3. Y_BOT is H-2-SIZE_Y.
- Reset and IDLE values:
  - X=X_C, Y=Y_C, v=0, cd=0.
  - scroll_amt=0, scroll_valid=0, dead=0, state IDLE.
- start in IDLE or DEAD:
  - Load X=X_C, Y=Y_C, v=-V_JUMP, cd=0.
  - Go to AIR.
  - start in AIR is ignored.
- IDLE and DEAD ignore frame_tick. In DEAD, position is frozen.
- AIR, on each frame_tick, all terms use pre-tick register values:
  - Horizontal step:
    - 0x04: x_new=X-X_STEP.
    - 0x07: x_new=X+X_STEP.
    - Any other keycode: x_new=X.
  - Horizontal wrap:
    - If x_new>X_MAX-SIZE_X, X=X_MIN.
    - Else if x_new<X_MIN, X=X_MAX-SIZE_X.
    - Otherwise X=x_new.
  - Vertical position: y_new=Y+v, computed signed at POS_W+2 bits with no wrap.
  - Velocity, in priority order:
    - land and v>=0: v=-V_BOUNCE.
    - Else keycode 0x2C and cd==0: v=-V_JUMP and cd=JUMP_CD.
    - Else v=min(v+GRAVITY, V_TERM).
  - cd decrements by 1 when cd>0 and it was not reloaded this tick.
  - Vertical outcome:
    - y_new>Y_BOT: go to DEAD, dead=1, Y unchanged.
    - Else if y_new<SCROLL_LINE: Y=SCROLL_LINE, scroll_amt=SCROLL_LINE-y_new, pulse scroll_valid.
    - Then clamp Y>=Y_TOP.
    - Otherwise Y=y_new.
- scroll_amt holds its value until the next scroll.

## Timing
- All outputs are registered. They reflect a tick or start one Clk after the input pulse.
- start and frame_tick in the same cycle: start wins and the tick is dropped.
- scroll_valid is high for exactly one Clk per qualifying tick.
- Reset_n low at any time forces the reset values immediately, including mid-tick. The first tick after release is processed normally.
- Back-to-back frame_tick on consecutive Clk cycles are each processed. There is no tick coalescing.

## Test plan
- Reset, then one start pulse and one tick:
  - After reset: X=304, Y=320, state IDLE, dead=0.
  - After the tick: Y=311, v=-8, state AIR.
- Rightward wrap: X=467 with keycode 0x07, then tick -> X=140. Leftward wrap: X=140 with keycode 0x04, then tick -> X=467.
- Bounce: v=3, land=1, Y=200, then tick -> Y=203, v=-7. Repeat with v=-2 and land=1 -> no bounce, v=-1.
- Jump cooldown: hold 0x2C from cd=0 -> v=-9, cd=18. On each following tick, v increments by 1 and clamps at 3. No re-jump until the tick where cd==0, which is 19 ticks after the jump.
- Scroll: Y=165, v=-9, then tick -> Y=160, scroll_amt=4, scroll_valid high for one Clk only.
- Death and restart: Y=445, v=3, then tick -> state DEAD, dead=1, Y=445. Further ticks leave everything unchanged. A start pulse -> X=304, Y=320, v=-9, state AIR. Assert Reset_n low mid-AIR -> IDLE values within the same cycle.
